// File: rtl/rowbias_gen_pkg.sv
// Shared grid constants, FSM state encoding and LFSR parameters for the row-bias generator.
package rowbias_gen_pkg;

    localparam int unsigned GRID_N = 9;
    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHUFFLE,
        ST_DONE
    } state_e;

    // Remainder via shifted conditional subtraction; draws only from the low byte of the LFSR word.
    function automatic logic [7:0] mod_sub(input logic [LFSR_W-1:0] word, input logic [7:0] d);
        logic [15:0] r;
        logic [15:0] ds;
        r = {8'h00, word[7:0]};
        for (int unsigned s = 0; s < 8; s++) begin
            ds = {8'h00, d} << (7 - s);
            if (ds != '0 && r >= ds) begin
                r = r - ds;
            end
        end
        return r[7:0];
    endfunction

endpackage

// File: rtl/rowbias_gen_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
module lfsr16
    import rowbias_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_value_i,
    input  logic              step_i,
    output logic [LFSR_W-1:0] value_o
);

    logic [LFSR_W-1:0] value_q;
    logic [LFSR_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_value_i;
        end else if (step_i) begin
            value_d = {1'b0, value_q[LFSR_W-1:1]} ^ (value_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/rowbias_gen.sv
// Row-bias generator: holds a 1-hot permutation table, reshuffles it with a Fisher-Yates
// walk driven by an LFSR, and answers 1-hot index lookups from the tile.
module rowbias_gen
    import rowbias_gen_pkg::*;
#(
    parameter int unsigned       GRID_LEN  = GRID_N,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                shuffle_i,
    input  logic [LFSR_W-1:0]   seed_i,
    output logic                ready_o,
    input  logic [GRID_LEN:0]   rqindex_i,
    input  logic                updaterowbias_i,
    output logic [GRID_LEN-1:0] rowbias_o,
    output logic                err_o
);

    localparam int unsigned IDX_W = $clog2(GRID_LEN);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [GRID_LEN-1:0] perm_q [GRID_LEN];
    logic [GRID_LEN-1:0] perm_d [GRID_LEN];
    logic [GRID_LEN-1:0] rowbias_q, rowbias_d;
    logic                err_q, err_d;

    logic                lfsr_load;
    logic                lfsr_step;
    logic [LFSR_W-1:0]   lfsr_value;
    logic [7:0]          j8;
    logic [IDX_W-1:0]    j_idx;
    logic                rq_onehot;
    logic [GRID_LEN-1:0] lookup_val;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (lfsr_load),
        .load_value_i (seed_i),
        .step_i       (lfsr_step),
        .value_o      (lfsr_value)
    );

    assign j8    = mod_sub(lfsr_value, 8'(idx_q) + 8'd1);
    assign j_idx = j8[IDX_W-1:0];

    // The sentinel bit never selects an entry, so a lone MSB yields an all-zero lookup.
    always_comb begin
        rq_onehot  = ($countones(rqindex_i) == 1);
        lookup_val = '0;
        for (int unsigned k = 0; k < GRID_LEN; k++) begin
            if (rqindex_i[k]) begin
                lookup_val = lookup_val | perm_q[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        perm_d    = perm_q;
        rowbias_d = rowbias_q;
        err_d     = err_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (updaterowbias_i) begin
                    if (rq_onehot) begin
                        rowbias_d = lookup_val;
                    end else begin
                        rowbias_d = '0;
                        err_d     = 1'b1;
                    end
                end
                if (shuffle_i) begin
                    state_d   = ST_SHUFFLE;
                    idx_d     = IDX_W'(GRID_LEN - 1);
                    lfsr_load = (seed_i != '0);
                end
            end
            ST_SHUFFLE: begin
                perm_d[idx_q] = perm_q[j_idx];
                perm_d[j_idx] = perm_q[idx_q];
                idx_d         = idx_q - 1'b1;
                lfsr_step     = 1'b1;
                if (idx_q == IDX_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rowbias_q <= '0;
            err_q     <= 1'b0;
            for (int unsigned k = 0; k < GRID_LEN; k++) begin
                perm_q[k] <= GRID_LEN'(1) << k;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rowbias_q <= rowbias_d;
            err_q     <= err_d;
            perm_q    <= perm_d;
        end
    end

    assign ready_o   = (state_q == ST_IDLE);
    assign rowbias_o = rowbias_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_rowbias_gen.sv
// Self-checking bench for rowbias_gen against a Fisher-Yates reference model.
module tb_rowbias_gen;

    localparam int GL = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          shuf;
    logic [15:0]   seed;
    logic          ready;
    logic [GL:0]   rqindex;
    logic          upd;
    logic [GL-1:0] rowbias;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_perm [GL];
    int unsigned m_lfsr;
    int unsigned m_rowbias;
    int unsigned m_err;
    logic [GL-1:0] tab_a [GL];
    logic [GL-1:0] tab_b [GL];
    int            mp_a  [GL];
    int            mp_b  [GL];

    rowbias_gen #(
        .GRID_LEN  (GL),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .shuffle_i       (shuf),
        .seed_i          (seed),
        .ready_o         (ready),
        .rqindex_i       (rqindex),
        .updaterowbias_i (upd),
        .rowbias_o       (rowbias),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned lfsr_next(input int unsigned x);
        int unsigned y;
        y = x >> 1;
        if (x & 1) y = y ^ 32'hB400;
        return y & 32'hFFFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < GL; k++) m_perm[k] = k;
        m_lfsr    = 32'hACE1;
        m_rowbias = 0;
        m_err     = 0;
    endtask

    // Durstenfeld shuffle from the top slot down to slot 1.
    task automatic model_shuffle(input logic [15:0] sd);
        int j, t;
        if (sd != 16'h0) m_lfsr = {16'h0, sd};
        for (int i = GL - 1; i >= 1; i--) begin
            j = int'(m_lfsr & 32'hFF) % (i + 1);
            t = m_perm[i];
            m_perm[i] = m_perm[j];
            m_perm[j] = t;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic do_lookup(input logic [GL:0] rq, input string tag);
        int k;
        if ($countones(rq) == 1) begin
            if (rq[GL]) begin
                m_rowbias = 0;
            end else begin
                k = 0;
                for (int b = 0; b < GL; b++) if (rq[b]) k = b;
                m_rowbias = 1 << m_perm[k];
            end
        end else begin
            m_rowbias = 0;
            m_err     = 1;
        end
        rqindex = rq;
        upd     = 1'b1;
        step();
        upd     = 1'b0;
        rqindex = '0;
        check({tag, "/rowbias"}, rowbias, m_rowbias);
        check({tag, "/err"}, err, m_err);
    endtask

    task automatic lookup_idx(input int idx, input string tag);
        logic [GL:0] rq;
        rq = '0;
        rq[idx] = 1'b1;
        do_lookup(rq, tag);
    endtask

    task automatic read_all(input string tag, output logic [GL-1:0] t [GL]);
        logic [GL-1:0] orv;
        int ones;
        orv  = '0;
        ones = 0;
        for (int k = 0; k < GL; k++) begin
            lookup_idx(k, tag);
            t[k] = rowbias;
            orv  = orv | rowbias;
            ones = ones + $countones(rowbias);
        end
        check({tag, "/or"}, orv, 9'h1FF);
        check({tag, "/ones"}, ones, GL);
    endtask

    task automatic do_shuffle(input logic [15:0] sd, input int look_idx, input bit hold,
                              input bit poke, input string tag);
        int cycles;
        int pre;
        seed = sd;
        shuf = 1'b1;
        if (look_idx >= 0) begin
            rqindex = '0;
            rqindex[look_idx] = 1'b1;
            upd = 1'b1;
        end
        pre = (look_idx >= 0) ? (1 << m_perm[look_idx]) : int'(m_rowbias);
        step();
        shuf    = 1'b0;
        upd     = 1'b0;
        rqindex = '0;
        m_rowbias = pre;
        check({tag, "/pre"}, rowbias, m_rowbias);
        model_shuffle(sd);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 40) begin
            if (hold) begin
                check({tag, "/hold"}, rowbias, m_rowbias);
                upd     = 1'b1;
                rqindex = '0;
                rqindex[$urandom_range(0, GL - 1)] = 1'b1;
            end
            if (poke && cycles == 2) begin
                shuf = 1'b1;
                seed = 16'($urandom_range(1, 65535));
            end else begin
                shuf = 1'b0;
            end
            step();
            cycles++;
        end
        shuf    = 1'b0;
        upd     = 1'b0;
        rqindex = '0;
        check({tag, "/busy_cycles"}, cycles, GL);
        check({tag, "/rowbias_after"}, rowbias, m_rowbias);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #3;
        check("reset/ready", ready, 1'b1);
        check("reset/rowbias", rowbias, 0);
        check("reset/err", err, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int diff_obs, diff_mod;
        rst_n   = 1'b0;
        shuf    = 1'b0;
        seed    = '0;
        rqindex = '0;
        upd     = 1'b0;
        #12;
        reset_dut();

        lookup_idx(2, "identity_idx2");
        check("identity_idx2/value", rowbias, 9'b000000100);
        read_all("identity_table", tab_a);

        do_shuffle(16'h0000, -1, 1'b0, 1'b0, "shuf_seed0");
        read_all("table_seed0", tab_a);
        for (int n = 0; n < 10; n++) lookup_idx($urandom_range(0, GL - 1), "rand_lookup");

        do_lookup(10'b1000000000, "sentinel");
        do_lookup(10'b0000000011, "multi_hot");
        lookup_idx(5, "after_err");
        do_lookup(10'b0000000000, "zero_rq");
        step();
        check("err_sticky", err, 1'b1);

        reset_dut();
        do_shuffle(16'h1234, -1, 1'b0, 1'b0, "shuf_1234_a");
        read_all("table_1234_a", tab_a);
        for (int k = 0; k < GL; k++) mp_a[k] = m_perm[k];
        reset_dut();
        do_shuffle(16'h1234, -1, 1'b0, 1'b0, "shuf_1234_b");
        read_all("table_1234_b", tab_b);
        diff_obs = 0;
        for (int k = 0; k < GL; k++) if (tab_a[k] !== tab_b[k]) diff_obs++;
        check("same_seed_same_perm", diff_obs, 0);
        reset_dut();
        do_shuffle(16'h4321, -1, 1'b0, 1'b0, "shuf_4321");
        read_all("table_4321", tab_b);
        for (int k = 0; k < GL; k++) mp_b[k] = m_perm[k];
        diff_obs = 0;
        diff_mod = 0;
        for (int k = 0; k < GL; k++) begin
            if (tab_a[k] !== tab_b[k]) diff_obs++;
            if (mp_a[k] != mp_b[k]) diff_mod++;
        end
        check("diff_seed_diff_count", diff_obs, diff_mod);

        do_shuffle(16'($urandom_range(1, 65535)), -1, 1'b1, 1'b0, "shuf_hold_upd");
        read_all("table_hold", tab_a);
        do_shuffle(16'($urandom_range(1, 65535)), -1, 1'b0, 1'b1, "shuf_poke");
        read_all("table_poke", tab_a);
        do_shuffle(16'h0000, -1, 1'b1, 1'b1, "shuf_chain");
        read_all("table_chain", tab_a);

        // Reset lands while the fourth swap cycle is in progress.
        seed = 16'h5555;
        shuf = 1'b1;
        step();
        shuf = 1'b0;
        step();
        step();
        step();
        check("midshuf/busy", ready, 1'b0);
        #2;
        reset_dut();
        lookup_idx(8, "midshuf_idx8");
        check("midshuf_idx8/value", rowbias, 9'b100000000);
        read_all("midshuf_identity", tab_a);

        do_shuffle(16'($urandom_range(1, 65535)), -1, 1'b0, 1'b0, "shuf_pre_combo");
        do_shuffle(16'($urandom_range(1, 65535)), 3, 1'b0, 1'b0, "combo_lookup_shuffle");
        read_all("table_combo", tab_a);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rowbias_gen.md
ROWBIAS_GEN -- requirements
Module: rowbias_gen

Interface
REQ-001 Parameter GRID_LEN, default 9, number of values per row; taken from the shared grid-dimension constants.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, LFSR value after reset.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 shuffle  input  1  pulse; start a new random permutation.
REQ-006 seed  input  16  LFSR reload value, sampled on an accepted shuffle.
REQ-007 ready  output  1  permutation stable; lookups honoured.
REQ-008 rqindex  input  GRID_LEN+1  1-hot request index from the tile; MSB is the exhausted sentinel.
REQ-009 updaterowbias  input  1  lookup strobe from the tile.
REQ-010 rowbias  output  GRID_LEN  1-hot candidate value to the tile, registered.
REQ-011 err  output  1  sticky flag: malformed rqindex seen.

Function
REQ-012 The block SHALL hold a permutation table perm[0..GRID_LEN-1], each entry 1-hot, all entries distinct at every cycle boundary.
REQ-013 The FSM SHALL have states IDLE, SHUFFLE, DONE; ready = 1 only in IDLE.
REQ-014 IDLE -> SHUFFLE when shuffle = 1; swap index i loaded with GRID_LEN-1; if seed != 0 the LFSR loads seed, else it keeps its value.
REQ-015 In SHUFFLE, each cycle: j = lfsr[7:0] mod (i+1), swap perm[i] and perm[j] (j = i is a no-op), decrement i, advance LFSR one step.
REQ-016 SHUFFLE -> DONE after the swap with i = 1; DONE -> IDLE unconditionally next cycle; total shuffle = GRID_LEN cycles from acceptance to ready.
REQ-017 The LFSR SHALL be 16-bit Galois, taps mask 16'hB400, advancing only in SHUFFLE.
REQ-018 In IDLE with updaterowbias = 1: if rqindex has exactly one bit set at position k < GRID_LEN, rowbias <= perm[k] on the next edge (latency 1 cycle).
REQ-019 If rqindex = sentinel (only MSB set), rowbias <= 0.
REQ-020 If rqindex is not 1-hot (zero or multiple bits), rowbias <= 0 and err <= 1; err clears only on reset.
REQ-021 updaterowbias while not IDLE SHALL be ignored; rowbias holds.
REQ-022 shuffle while in SHUFFLE or DONE SHALL be ignored.
REQ-023 shuffle and updaterowbias in the same IDLE cycle: the lookup uses the pre-shuffle table, then the shuffle starts.
REQ-024 rowbias SHALL hold its value whenever no lookup is performed.

Reset
REQ-025 On reset low, asynchronously: state IDLE, perm[k] = 1 << k (identity), lfsr = LFSR_SEED, i = 0, rowbias = 0, err = 0, ready = 1 once the FSM is in IDLE.
REQ-026 Reset asserted mid-shuffle SHALL abandon the shuffle and restore the identity table; no partial permutation persists.
REQ-027 Deassertion SHALL take effect on the first rising edge after release; no lookup performed on that edge unless updaterowbias is high.

Structure
REQ-028 The FSM state enum, LFSR width and tap mask SHALL live in the shared grid package next to GRID_LEN.
REQ-029 The LFSR SHALL be a sub-module lfsr16 (inputs: load, load_value, step; output: value).
REQ-030 mod (i+1) SHALL be computed by repeated conditional subtraction, combinational, 8-bit operand; no divider IP.

Verification
REQ-031 Reset, then lookup rqindex = 10'b0000000100 -> rowbias = 9'b000000100 one cycle later; err = 0.
REQ-032 shuffle with seed = 0 -> ready low for exactly 9 cycles, then high; lookups of all 9 indices return 9 distinct 1-hot values whose OR = 9'h1FF.
REQ-033 Two shuffles with the same nonzero seed 16'h1234 after reset -> identical permutations; a different seed yields a different permutation.
REQ-034 Lookup rqindex = 10'b1000000000 -> rowbias = 0, err = 0; rqindex = 10'b0000000011 -> rowbias = 0, err = 1 and stays 1 until reset.
REQ-035 updaterowbias held high during a shuffle -> rowbias unchanged throughout; reset low on the 4th shuffle cycle -> identity table and ready restored, lookup of index 8 returns 9'b100000000.
REQ-036 shuffle and updaterowbias with rqindex bit 3 in the same cycle -> rowbias equals pre-shuffle perm[3]; shuffle completes 9 cycles later.
